keen_register_file_scoreboard: RTL and testbench
================================================

# keen_register_file_scoreboard

Parametrised multi-port register file with registered reads, per-register busy scoreboard and optional same-cycle write-to-read forwarding. It sits between the decode/issue stage and the execute/writeback stages of the keen core. Issue reserves a destination register. Writeback writes the result and releases the register. Operand reads return data plus the busy status, so issue can stall on hazards.

## Interface

- `REGISTERS`, 32, number of architectural registers (≥2); register 0 is hardwired zero
- `WORD_SIZE`, 32, data width in bits
- `READS`, 2, number of read ports (≥1)
- `WRITES`, 1, number of write ports (≥1)
- `ADDRESS_SIZE`, `$clog2(REGISTERS)`, localparam, address width

- `clk`  in  1  single clock; all state updates on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `read_addresses`  in  READS*ADDRESS_SIZE  port i at bits [i*ADDRESS_SIZE +: ADDRESS_SIZE]
- `read_enables`  in  READS  per-port read strobe
- `read_data`  out  READS*WORD_SIZE  registered read data, port i at [i*WORD_SIZE +: WORD_SIZE]
- `read_busy`  out  READS  registered busy flag of the register read on port i
- `write_addresses`  in  WRITES*ADDRESS_SIZE  packed like `read_addresses`
- `write_data`  in  WRITES*WORD_SIZE  packed like `read_data`
- `write_enables`  in  WRITES  per-port write strobe; a write also clears the register's busy bit
- `reserve_address`  in  ADDRESS_SIZE  destination register being issued
- `reserve_enable`  in  1  sets busy bit of `reserve_address`
- `busy`  out  REGISTERS  scoreboard vector, bit r = register r awaiting writeback

## Operation

- Storage is REGISTERS-1 words (r1..r(REGISTERS-1)). r0 reads as 0, is never busy, and ignores writes and reserves.
- Write: on the edge with `write_enables[j]`=1 and address≠0, the register takes `write_data[j]` and its busy bit clears.
- Write conflict: two or more enabled ports target the same address. The highest-index port's data is stored.
- Reserve: on the edge with `reserve_enable`=1 and address≠0, the busy bit sets.
- Reserve and write to the same address on the same edge: the data is written and the busy bit ends **set**, because the new producer wins.
- Read: on the edge with `read_enables[i]`=1, `read_data[i]` and `read_busy[i]` load the addressed register's value and busy bit. With the strobe low, both hold their previous value.
- Address ≥ REGISTERS (non-power-of-two depth): read returns 0 and not-busy; write and reserve are ignored.
- Reset (`reset_n`=0, asynchronous assert): all registers, `busy`, `read_data` and `read_busy` are forced to 0 immediately. Any in-flight write, reserve or read on the edge where reset is asserted is discarded.
- Reset release: normal operation starts at the first rising `clk` after `reset_n` rises. Deassertion is expected to be synchronised upstream.

## Timing

- Read latency is 1 cycle: the address is presented in cycle N and the data is valid after edge N, stable through cycle N+1.
- Write latency is 1 cycle: the value is architecturally visible to a read issued in cycle N+1 without forwarding.
- `busy` is a direct register output, updated on the same edge as the reserve or write.
- There are no combinational paths from any input to any output.

## Configuration

- Macro `KEEN_REGISTER_FILE_BYPASS_EN`.
- Defined: a read and an enabled write to the same nonzero address on the same edge return the write data. On a write conflict, the highest-index port's data is returned. `read_busy` reflects the post-edge busy state, so a write clears it and a same-edge reserve sets it.
- Undefined: such a read returns the pre-edge register value and the pre-edge busy bit. No forwarding muxes are built.

## Test plan

- Reset: hold `reset_n`=0 mid-run after loading r5=0xDEADBEEF, then release and read r5 → `read_data`=0, `read_busy`=0, `busy`=0 immediately on assert, no clock needed.
- Write/read: write r3=0x12345678 in cycle N, read r3 on port 1 in cycle N+1 → `read_data[1]`=0x12345678 after the next edge. Write r0=0xFFFFFFFF, then read r0 → 0.
- Scoreboard: reserve r7, then read r7 → `busy[7]`=1, `read_busy`=1. Write r7=0xA5 → `busy[7]`=0. Reserve and write r7 on the same edge → `busy[7]`=1, data 0xA5.
- Write conflict (WRITES=2): port 0 writes r4=0x1, port 1 writes r4=0x2 on the same edge → r4=0x2.
- Same-edge read/write of r9 (old 0x11, new 0x22): with `KEEN_REGISTER_FILE_BYPASS_EN` → 0x22. Without → 0x11, then 0x22 on the next read.
- Hold: deassert `read_enables[0]` while changing the address and writing → `read_data[0]` and `read_busy[0]` are unchanged.

Source files
------------

// File: rtl/keen_register_file_scoreboard.sv
// keen_register_file_scoreboard: multi-port register file with registered reads and a busy scoreboard.
// Define KEEN_REGISTER_FILE_BYPASS_EN to forward same-edge writes and busy updates to reads.
module keen_register_file_scoreboard #(
  parameter int REGISTERS = 32,
  parameter int WORD_SIZE = 32,
  parameter int READS = 2,
  parameter int WRITES = 1,
  localparam int ADDRESS_SIZE = $clog2(REGISTERS)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [READS*ADDRESS_SIZE-1:0]  read_addresses,
  input  logic [READS-1:0]               read_enables,
  output logic [READS*WORD_SIZE-1:0]     read_data,
  output logic [READS-1:0]               read_busy,
  input  logic [WRITES*ADDRESS_SIZE-1:0] write_addresses,
  input  logic [WRITES*WORD_SIZE-1:0]    write_data,
  input  logic [WRITES-1:0]              write_enables,
  input  logic [ADDRESS_SIZE-1:0]        reserve_address,
  input  logic                           reserve_enable,
  output logic [REGISTERS-1:0]           busy
);
  logic [WORD_SIZE-1:0] regs_q [REGISTERS];
  logic [WORD_SIZE-1:0] regs_d [REGISTERS];
  logic [REGISTERS-1:0] busy_q, busy_d;
  logic [READS*WORD_SIZE-1:0] rdata_q, rdata_d;
  logic [READS-1:0] rbusy_q, rbusy_d;

  // r0 and addresses beyond the last register are inert; r0 storage stays constant zero
  function automatic logic live(input logic [ADDRESS_SIZE-1:0] a);
    return a != '0 && int'(a) < REGISTERS;
  endfunction

  always_comb begin
    logic [ADDRESS_SIZE-1:0] a;
    a = '0;
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < WRITES; j++) begin
      a = write_addresses[j*ADDRESS_SIZE +: ADDRESS_SIZE];
      if (write_enables[j] && live(a)) begin
        regs_d[a] = write_data[j*WORD_SIZE +: WORD_SIZE];
        busy_d[a] = 1'b0;
      end
    end
    if (reserve_enable && live(reserve_address)) busy_d[reserve_address] = 1'b1;
  end

  always_comb begin
    logic [ADDRESS_SIZE-1:0] a;
    a = '0;
    rdata_d = rdata_q;
    rbusy_d = rbusy_q;
    for (int i = 0; i < READS; i++) begin
      a = read_addresses[i*ADDRESS_SIZE +: ADDRESS_SIZE];
      if (read_enables[i]) begin
`ifdef KEEN_REGISTER_FILE_BYPASS_EN
        rdata_d[i*WORD_SIZE +: WORD_SIZE] = live(a) ? regs_d[a] : '0;
        rbusy_d[i] = live(a) && busy_d[a];
`else
        rdata_d[i*WORD_SIZE +: WORD_SIZE] = live(a) ? regs_q[a] : '0;
        rbusy_d[i] = live(a) && busy_q[a];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q  <= '{default: '0};
      busy_q  <= '0;
      rdata_q <= '0;
      rbusy_q <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      rbusy_q <= rbusy_d;
    end
  end

  assign read_data = rdata_q;
  assign read_busy = rbusy_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_keen_register_file_scoreboard.sv
// tb_keen_register_file_scoreboard: directed and randomized checks against an array-based model of the register file.
module tb_keen_register_file_scoreboard;
  localparam int R  = 24;
  localparam int AW = 5;
  localparam int W  = 32;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NR*AW-1:0] read_addresses;
  logic [NR-1:0]    read_enables;
  logic [NR*W-1:0]  read_data;
  logic [NR-1:0]    read_busy;
  logic [NW*AW-1:0] write_addresses;
  logic [NW*W-1:0]  write_data;
  logic [NW-1:0]    write_enables;
  logic [AW-1:0]    reserve_address;
  logic             reserve_enable;
  logic [R-1:0]     busy;

  int total = 0;
  int bad = 0;
  logic chk_on = 1'b0;

  logic [W-1:0] m_mem [R];
  logic [R-1:0] m_bsy;
  logic [W-1:0] m_rd [NR];
  logic         m_rb [NR];

  keen_register_file_scoreboard #(.REGISTERS(R), .WORD_SIZE(W), .READS(NR), .WRITES(NW)) dut (
    .clk(clk), .reset_n(reset_n),
    .read_addresses(read_addresses), .read_enables(read_enables),
    .read_data(read_data), .read_busy(read_busy),
    .write_addresses(write_addresses), .write_data(write_data), .write_enables(write_enables),
    .reserve_address(reserve_address), .reserve_enable(reserve_enable),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: registers as an array, written in port order, reserve applied last
  always @(posedge clk or negedge reset_n) begin
    logic [W-1:0] pm [R];
    logic [R-1:0] pb;
    int a;
    if (!reset_n) begin
      for (int r = 0; r < R; r++) m_mem[r] = '0;
      m_bsy = '0;
      for (int i = 0; i < NR; i++) begin
        m_rd[i] = '0;
        m_rb[i] = 1'b0;
      end
    end else begin
      pm = m_mem;
      pb = m_bsy;
      for (int j = 0; j < NW; j++) begin
        a = int'(write_addresses[j*AW +: AW]);
        if (write_enables[j] && a > 0 && a < R) begin
          m_mem[a] = write_data[j*W +: W];
          m_bsy[a] = 1'b0;
        end
      end
      a = int'(reserve_address);
      if (reserve_enable && a > 0 && a < R) m_bsy[a] = 1'b1;
      for (int i = 0; i < NR; i++) begin
        a = int'(read_addresses[i*AW +: AW]);
        if (read_enables[i]) begin
          if (a >= R) begin
            m_rd[i] = '0;
            m_rb[i] = 1'b0;
          end else begin
`ifdef KEEN_REGISTER_FILE_BYPASS_EN
            m_rd[i] = m_mem[a];
            m_rb[i] = m_bsy[a];
`else
            m_rd[i] = pm[a];
            m_rb[i] = pb[a];
`endif
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_busy", W'(busy), W'(m_bsy));
      for (int i = 0; i < NR; i++) begin
        chk("model_read_data", read_data[i*W +: W], m_rd[i]);
        chk("model_read_busy", W'(read_busy[i]), W'(m_rb[i]));
      end
    end
  end

  task automatic idle();
    read_enables = '0;
    write_enables = '0;
    reserve_enable = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int p, input int a, input logic [W-1:0] d);
    write_addresses[p*AW +: AW] = AW'(a);
    write_data[p*W +: W] = d;
    write_enables[p] = 1'b1;
  endtask

  task automatic rd(input int p, input int a);
    read_addresses[p*AW +: AW] = AW'(a);
    read_enables[p] = 1'b1;
  endtask

  task automatic rsv(input int a);
    reserve_address = AW'(a);
    reserve_enable = 1'b1;
  endtask

  initial begin
    read_addresses = '0;
    write_addresses = '0;
    write_data = '0;
    reserve_address = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("reset_busy", W'(busy), 32'h0);
    chk("reset_read_data", read_data[W-1:0], 32'h0);
    chk_on = 1'b1;
    wr(0, 5, 32'hDEADBEEF);
    rsv(6);
    tick();
    rd(0, 5);
    tick();
    chk("r5_loaded", read_data[W-1:0], 32'hDEADBEEF);
    chk("r6_busy", W'(busy[6]), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_busy", W'(busy), 32'h0);
    chk("async_reset_read_data", read_data[W-1:0], 32'h0);
    chk("async_reset_read_busy", W'(read_busy), 32'h0);
    #1;
    reset_n = 1'b1;
    rd(0, 5);
    tick();
    chk("r5_after_reset", read_data[W-1:0], 32'h0);
    wr(0, 3, 32'h12345678);
    tick();
    rd(1, 3);
    tick();
    chk("r3_port1", read_data[W +: W], 32'h12345678);
    wr(0, 0, 32'hFFFFFFFF);
    tick();
    rd(0, 0);
    tick();
    chk("r0_zero", read_data[W-1:0], 32'h0);
    rsv(7);
    tick();
    rd(0, 7);
    tick();
    chk("r7_reserved", W'(busy[7]), 32'h1);
    chk("r7_read_busy", W'(read_busy[0]), 32'h1);
    wr(1, 7, 32'hA5);
    tick();
    chk("r7_released", W'(busy[7]), 32'h0);
    wr(0, 7, 32'hA5);
    rsv(7);
    tick();
    chk("r7_reserve_wins", W'(busy[7]), 32'h1);
    rd(0, 7);
    tick();
    chk("r7_data", read_data[W-1:0], 32'hA5);
    chk("r7_busy_read", W'(read_busy[0]), 32'h1);
    wr(0, 4, 32'h1);
    wr(1, 4, 32'h2);
    tick();
    rd(0, 4);
    tick();
    chk("conflict_high_port", read_data[W-1:0], 32'h2);
    wr(0, 9, 32'h11);
    tick();
    wr(1, 9, 32'h22);
    rd(0, 9);
    tick();
`ifdef KEEN_REGISTER_FILE_BYPASS_EN
    chk("r9_same_edge", read_data[W-1:0], 32'h22);
`else
    chk("r9_same_edge", read_data[W-1:0], 32'h11);
`endif
    rd(0, 9);
    tick();
    chk("r9_next_read", read_data[W-1:0], 32'h22);
    read_addresses[AW-1:0] = AW'(3);
    wr(0, 9, 32'h33);
    rsv(9);
    tick();
    chk("hold_data", read_data[W-1:0], 32'h22);
    chk("hold_busy", W'(read_busy[0]), 32'h0);
    chk("r9_busy", W'(busy[9]), 32'h1);
    wr(0, 25, 32'hCAFEF00D);
    rsv(30);
    rd(1, 30);
    tick();
    chk("oob_read", read_data[W +: W], 32'h0);
    chk("oob_read_busy", W'(read_busy[1]), 32'h0);
    for (int n = 0; n < 3000; n++) begin
      read_enables = NR'($urandom);
      read_addresses = NR*AW'($urandom);
      write_enables = NW'($urandom);
      write_addresses = NW*AW'($urandom);
      if ($urandom_range(0, 3) == 0) write_addresses[AW +: AW] = write_addresses[AW-1:0];
      if ($urandom_range(0, 2) == 0) read_addresses[AW-1:0] = write_addresses[AW-1:0];
      write_data = {$urandom, $urandom};
      reserve_enable = 1'($urandom);
      reserve_address = ($urandom_range(0, 3) == 0) ? write_addresses[AW-1:0] : AW'($urandom);
      if (n == 1500) begin
        #2;
        reset_n = 1'b0;
        #1;
        chk("rand_async_reset", W'(busy), 32'h0);
        reset_n = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    idle();
    tick();
    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
